// File: rtl/ram_ctrl_if.sv
// rtl/ram_ctrl_if.sv - request/response bundle between a memory master and ram_ctrl
// Parameters must match the ram_ctrl instance they connect to.
interface ram_ctrl_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10
);
   logic                    req;
   logic                    we;
   logic [WIDTH/8-1:0]      be;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [WIDTH-1:0]        inData;
   logic                    clear;
   logic                    ready;
   logic                    busy;
   logic                    outValid;
   logic [WIDTH-1:0]        outData;

   modport master (
      output req, we, be, addr, inData, clear,
      input  ready, busy, outValid, outData
   );

   modport slave (
      input  req, we, be, addr, inData, clear,
      output ready, busy, outValid, outData
   );
endinterface

// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - byte-enabled data RAM with registered read port and zero-sweep engine
// Define RAM_CLEAR_EN to build the INIT/CLEAR sweep; otherwise INIT lasts one cycle.
module ram_ctrl #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 10
) (
   input  logic       clk,
   input  logic       reset,
   ram_ctrl_if.slave  bus
);
   localparam int NB    = WIDTH / 8;
   localparam int DEPTH = 1 << ADDR_WIDTH;

   typedef enum logic [1:0] {
      INIT  = 2'd0,
      IDLE  = 2'd1,
      CLEAR = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic                  out_valid_q, out_valid_d;
   logic [WIDTH-1:0]      out_data_q, out_data_d;

   logic [WIDTH-1:0]      mem_q [DEPTH];

   logic                  wr_en;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [WIDTH-1:0]      wr_data;
   logic [NB-1:0]         wr_be;
   logic                  accept;

`ifdef RAM_CLEAR_EN
   // One extra bit so the terminal compare happens before any wrap.
   localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH - 1);
   logic [ADDR_WIDTH:0]   cnt_q, cnt_d;
`else
   logic                  unused_clear;
   assign unused_clear = bus.clear;
`endif

   assign accept = bus.req && (state_q == IDLE);

   always_comb begin
      state_d     = state_q;
      out_valid_d = 1'b0;
      out_data_d  = out_data_q;
      wr_en       = 1'b0;
      wr_addr     = bus.addr;
      wr_data     = bus.inData;
      wr_be       = bus.be;
`ifdef RAM_CLEAR_EN
      cnt_d       = cnt_q;
`endif
      case (state_q)
         INIT, CLEAR: begin
`ifdef RAM_CLEAR_EN
            wr_en   = 1'b1;
            wr_addr = cnt_q[ADDR_WIDTH-1:0];
            wr_data = '0;
            wr_be   = '1;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end
`else
            state_d = IDLE;
`endif
         end
         IDLE: begin
            if (accept) begin
               if (bus.we) begin
                  wr_en = 1'b1;
               end else begin
                  out_valid_d = 1'b1;
                  out_data_d  = mem_q[bus.addr];
               end
            end
`ifdef RAM_CLEAR_EN
            // A request accepted on the same edge finishes before the sweep starts.
            if (bus.clear) begin
               state_d = CLEAR;
               cnt_d   = '0;
            end
`endif
         end
         default: state_d = INIT;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= INIT;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
`ifdef RAM_CLEAR_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
`ifdef RAM_CLEAR_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // The array has no reset; the sweep is the only way to zero it.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         for (int k = 0; k < NB; k++) begin
            if (wr_be[k]) begin
               mem_q[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
            end
         end
      end
   end

   assign bus.ready    = (state_q == IDLE);
`ifdef RAM_CLEAR_EN
   assign bus.busy     = (state_q == INIT) || (state_q == CLEAR);
`else
   assign bus.busy     = 1'b0;
`endif
   assign bus.outValid = out_valid_q;
   assign bus.outData  = out_data_q;
endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - scoreboard bench for ram_ctrl, with or without RAM_CLEAR_EN
module tb_ram_ctrl;
   localparam int WIDTH      = 32;
   localparam int ADDR_WIDTH = 10;
   localparam int DEPTH      = 1 << ADDR_WIDTH;
`ifdef RAM_CLEAR_EN
   localparam bit SWEEP = 1'b1;
`else
   localparam bit SWEEP = 1'b0;
`endif

   logic clk;
   logic reset;
   int   n_checks = 0;
   int   n_fails  = 0;
   int   n_valid  = 0;
   int   n_reads  = 0;

   logic [WIDTH-1:0] exp_q [$];
   logic [WIDTH-1:0] model [int];

   ram_ctrl_if #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) bus ();

   ram_ctrl #(.WIDTH(WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WIDTH-1:0] mem_get(input int a);
      return model.exists(a) ? model[a] : '0;
   endfunction

   always @(negedge clk) begin
      if (bus.outValid === 1'b1) begin
         n_valid++;
         if (exp_q.size() == 0) check("unexpected_valid", 1, 0);
         else                   check("rdata", bus.outData, exp_q.pop_front());
      end
   end

   // Called at a negedge; drives one request for the next rising edge.
   task automatic access(input bit wr, input int a, input logic [WIDTH-1:0] d,
                         input logic [3:0] b, input bit clr);
      check("ready_before_req", bus.ready, 1);
      bus.req    = 1'b1;
      bus.we     = wr;
      bus.addr   = ADDR_WIDTH'(a);
      bus.inData = d;
      bus.be     = b;
      bus.clear  = clr;
      if (wr) begin
         logic [WIDTH-1:0] m;
         m = mem_get(a);
         for (int k = 0; k < 4; k++) if (b[k]) m[8*k +: 8] = d[8*k +: 8];
         model[a] = m;
      end else begin
         exp_q.push_back(mem_get(a));
         n_reads++;
      end
      if (clr && SWEEP) model.delete();
      @(negedge clk);
      bus.req   = 1'b0;
      bus.clear = 1'b0;
   endtask

   // Counts negedges until ready; optionally holds a read req for the first 50 cycles.
   task automatic wait_ready(input bit hold, output int n, output bit busy_ok);
      n = 0;
      busy_ok = 1'b1;
      if (hold) begin
         bus.req = 1'b1; bus.we = 1'b0; bus.addr = 10'h012;
      end
      while (bus.ready !== 1'b1 && n < 4000) begin
         if (bus.busy !== SWEEP) busy_ok = 1'b0;
         @(negedge clk);
         n++;
         if (n == 50) bus.req = 1'b0;
      end
      bus.req = 1'b0;
      if (n >= 4000) check("ready_timeout", 1, 0);
   endtask

   initial begin
      int n;
      bit bok;
      bus.req = 0; bus.we = 0; bus.be = 0; bus.addr = 0; bus.inData = 0; bus.clear = 0;
      reset = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_ready", bus.ready, 0);
      check("rst_busy", bus.busy, SWEEP);
      check("rst_valid", bus.outValid, 0);
      check("rst_data", bus.outData, 0);
      reset = 1'b1;
      wait_ready(1'b0, n, bok);
      check("init_len", n, SWEEP ? DEPTH : 1);
      check("init_busy", bok, 1);
      check("idle_busy", bus.busy, 0);

      if (SWEEP) begin
         access(0, 10'h000, 0, 0, 0);
         access(0, 10'h3FF, 0, 0, 0);
      end

      access(1, 10'h012, 32'hDEADBEEF, 4'hF, 0);
      check("write_no_valid", bus.outValid, 0);
      access(1, 10'h012, 32'h000000AA, 4'h1, 0);
      access(0, 10'h012, 0, 0, 0);
      check("read_data_direct", bus.outData, 32'hDEADBEAA);
      @(negedge clk);
      check("valid_one_cycle", bus.outValid, 0);

      access(1, 10'h012, 32'h12345678, 4'h0, 0);
      check("be0_no_valid", bus.outValid, 0);
      access(0, 10'h012, 0, 0, 0);

      // Fill a small window, then random partial writes mixed with back-to-back reads.
      for (int i = 0; i < 16; i++) access(1, 10'h100 + i, $urandom, 4'hF, 0);
      for (int i = 0; i < 40; i++) begin
         int a;
         a = 10'h100 + $urandom_range(0, 15);
         if ($urandom_range(0, 1) == 0) access(1, a, $urandom, 4'($urandom_range(0, 15)), 0);
         else access(0, a, 0, 0, 0);
      end
      for (int i = 0; i < 4; i++) access(0, 10'h100 + i, 0, 0, 0);
      check("b2b_valid_held", bus.outValid, 1);
      @(negedge clk);

      // Read and clear on the same edge: the read sees pre-clear contents.
      access(0, 10'h012, 0, 0, 1);
      wait_ready(1'b1, n, bok);
      check("clear_len", n, SWEEP ? DEPTH : 0);
      check("clear_busy", bok, 1);
      check("after_clear_ready", bus.ready, 1);
      access(0, 10'h012, 0, 0, 0);
      @(negedge clk);

      access(1, 10'h005, 32'h11223344, 4'hF, 0);
      access(0, 10'h005, 0, 0, 0);
      access(0, 10'h005, 0, 0, 1);
      if (SWEEP) repeat (500) @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_rst_ready", bus.ready, 0);
      check("mid_rst_busy", bus.busy, SWEEP);
      check("mid_rst_valid", bus.outValid, 0);
      check("mid_rst_data", bus.outData, 0);
      @(negedge clk);
      reset = 1'b1;
      if (SWEEP) model.delete();
      wait_ready(1'b0, n, bok);
      check("resweep_len", n, SWEEP ? DEPTH : 1);
      check("resweep_busy", bok, 1);

      access(1, 10'h020, 32'hCAFEF00D, 4'hF, 0);
      access(1, 10'h020, 32'h00BE0000, 4'h4, 0);
      access(0, 10'h020, 0, 0, 0);
      if (SWEEP) access(0, 10'h005, 0, 0, 0);
      repeat (3) @(negedge clk);

      check("pending_reads", exp_q.size(), 0);
      check("valid_count", n_valid, n_reads);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end
endmodule
